// File: rtl/digit_serial_subtractor.sv
// Multi-cycle unsigned subtractor: {bout, diff} = a - b - bin, DIGIT_WIDTH bits per enabled clock, LSB first.
// Valid/ready on both sides; results are held on the outputs until the next operation completes.
module digit_serial_subtractor #(
  parameter int DATA_WIDTH  = 16,
  parameter int DIGIT_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] iv_a,
  input  logic [DATA_WIDTH-1:0] iv_b,
  input  logic                  i_bin,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] ov_diff,
  output logic                  o_bout
);

  localparam int NUM_DIGITS = DATA_WIDTH / DIGIT_WIDTH;
  localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

  generate
    if (DATA_WIDTH % DIGIT_WIDTH != 0) begin : g_bad_width
      $error("DATA_WIDTH must be a multiple of DIGIT_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic                  r_borrow;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_diff;
  logic                  r_bout;

  logic [DIGIT_WIDTH-1:0] w_a_slice;
  logic [DIGIT_WIDTH-1:0] w_b_slice;
  logic [DIGIT_WIDTH:0]   w_sub;
  logic [DATA_WIDTH-1:0]  w_acc_next;
  logic                   w_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else if (i_en) begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_ready      = 1'b0;
    o_valid      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        o_valid = 1'b1;
        if (i_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // One DIGIT_WIDTH+1 bit subtract per cycle; the top bit is the borrow into the next slice.
  always_comb begin
    w_last     = (r_cnt == LAST_DIGIT);
    w_a_slice  = r_a[int'(r_cnt)*DIGIT_WIDTH +: DIGIT_WIDTH];
    w_b_slice  = r_b[int'(r_cnt)*DIGIT_WIDTH +: DIGIT_WIDTH];
    w_sub      = {1'b0, w_a_slice} - {1'b0, w_b_slice} - (DIGIT_WIDTH+1)'(r_borrow);
    w_acc_next = r_acc;
    w_acc_next[int'(r_cnt)*DIGIT_WIDTH +: DIGIT_WIDTH] = w_sub[DIGIT_WIDTH-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_acc    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
    end else if (i_en) begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_a      <= iv_a;
            r_b      <= iv_b;
            r_borrow <= i_bin;
            r_cnt    <= '0;
            r_acc    <= '0;
          end
        end
        S_RUN: begin
          r_acc    <= w_acc_next;
          r_borrow <= w_sub[DIGIT_WIDTH];
          r_cnt    <= w_last ? '0 : r_cnt + CNT_W'(1);
          // Outputs only change on DONE entry so the previous result stays visible while running.
          if (w_last) begin
            r_diff <= w_acc_next;
            r_bout <= w_sub[DIGIT_WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign ov_diff = r_diff;
  assign o_bout  = r_bout;

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Directed and randomized checks of digit_serial_subtractor at the default 16/4 configuration.
module tb_digit_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        in_valid;
  logic        out_ready_dut;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        ds_ready;
  logic [15:0] diff;
  logic        bout;

  int n_checks = 0;
  int n_errors = 0;

  digit_serial_subtractor #(.DATA_WIDTH(16), .DIGIT_WIDTH(4)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_en    (en),
    .i_valid (in_valid),
    .o_ready (out_ready_dut),
    .iv_a    (a),
    .iv_b    (b),
    .i_bin   (bin),
    .o_valid (out_valid),
    .i_ready (ds_ready),
    .ov_diff (diff),
    .o_bout  (bout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one edge; caller has made sure the block is in IDLE with en=1.
  task automatic accept(input logic [15:0] va, input logic [15:0] vb, input logic vbin);
    a        = va;
    b        = vb;
    bin      = vbin;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cycles, output bit timed_out);
    cycles = 0;
    while (!out_valid && cycles < 300) begin
      tick();
      cycles++;
    end
    timed_out = !out_valid;
  endtask

  task automatic release_result();
    ds_ready = 1'b1;
    tick();
    ds_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if (out_ready_dut !== 1'b1 || out_valid !== 1'b0 || diff !== 16'h0 || bout !== 1'b0) begin
      n_errors++;
      $display("FAIL reset: ready=%b valid=%b diff=%h bout=%b, want 1 0 0000 0",
               out_ready_dut, out_valid, diff, bout);
    end
  endtask

  task automatic test_basic();
    logic [15:0] va [3] = '{16'h1234, 16'h0000, 16'h8000};
    logic [15:0] vb [3] = '{16'h0034, 16'h0001, 16'h7FFF};
    logic        vi [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] ed [3] = '{16'h1200, 16'hFFFF, 16'h0000};
    logic        eb [3] = '{1'b0, 1'b1, 1'b0};
    int cyc;
    bit to;
    for (int i = 0; i < 3; i++) begin
      accept(va[i], vb[i], vi[i]);
      wait_valid(cyc, to);
      n_checks++;
      if (to || cyc != 4) begin
        n_errors++;
        $display("FAIL basic_latency[%0d]: got %0d cycles (timeout=%0d), want 4", i, cyc, to);
      end
      n_checks++;
      if (diff !== ed[i] || bout !== eb[i]) begin
        n_errors++;
        $display("FAIL basic_result[%0d]: diff=%h bout=%b, want %h %b", i, diff, bout, ed[i], eb[i]);
      end
      release_result();
      n_checks++;
      if (out_ready_dut !== 1'b1 || out_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL basic_idle[%0d]: ready=%b valid=%b, want 1 0", i, out_ready_dut, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    bit to;
    accept(16'h5678, 16'h1234, 1'b0);
    wait_valid(cyc, to);
    n_checks++;
    if (to || diff !== 16'h4444 || bout !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_result: diff=%h bout=%b timeout=%0d, want 4444 0", diff, bout, to);
    end
    a        = 16'hFFFF;
    b        = 16'h0001;
    bin      = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_ready_dut !== 1'b0 || diff !== 16'h4444 || bout !== 1'b0) begin
        n_errors++;
        $display("FAIL bp_hold[%0d]: valid=%b ready=%b diff=%h bout=%b, want 1 0 4444 0",
                 i, out_valid, out_ready_dut, diff, bout);
      end
    end
    in_valid = 1'b0;
    release_result();
    tick();
    n_checks++;
    if (out_ready_dut !== 1'b1 || out_valid !== 1'b0 || diff !== 16'h4444) begin
      n_errors++;
      $display("FAIL bp_idle_hold: ready=%b valid=%b diff=%h, want 1 0 4444",
               out_ready_dut, out_valid, diff);
    end
  endtask

  task automatic test_enable_stall();
    int cyc;
    bit to;
    // 0x9ABC - 0x1111 - 1 = 0x89AA
    accept(16'h9ABC, 16'h1111, 1'b1);
    tick();
    en = 1'b0;
    a  = 16'h0000;
    b  = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || out_ready_dut !== 1'b0) begin
        n_errors++;
        $display("FAIL stall_frozen[%0d]: valid=%b ready=%b, want 0 0", i, out_valid, out_ready_dut);
      end
    end
    en = 1'b1;
    wait_valid(cyc, to);
    n_checks++;
    if (to || cyc + 4 != 7) begin
      n_errors++;
      $display("FAIL stall_latency: got %0d cycles after accept (timeout=%0d), want 7", cyc + 4, to);
    end
    n_checks++;
    if (diff !== 16'h89AA || bout !== 1'b0) begin
      n_errors++;
      $display("FAIL stall_result: diff=%h bout=%b, want 89aa 0", diff, bout);
    end
    release_result();
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    bit to;
    accept(16'h1111, 16'h2222, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (out_ready_dut !== 1'b1 || out_valid !== 1'b0 || diff !== 16'h0 || bout !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_state: ready=%b valid=%b diff=%h bout=%b, want 1 0 0000 0",
               out_ready_dut, out_valid, diff, bout);
    end
    accept(16'hFFFF, 16'hFFFF, 1'b1);
    wait_valid(cyc, to);
    n_checks++;
    if (to || cyc != 4 || diff !== 16'hFFFF || bout !== 1'b1) begin
      n_errors++;
      $display("FAIL midrst_next_op: cyc=%0d diff=%h bout=%b timeout=%0d, want 4 ffff 1",
               cyc, diff, bout, to);
    end
    release_result();
  endtask

  task automatic test_random();
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rbin;
    logic [16:0] exp_full;
    int cyc;
    for (int n = 0; n < 100; n++) begin
      ra       = 16'($urandom());
      rb       = 16'($urandom());
      rbin     = 1'($urandom_range(0, 1));
      exp_full = {1'b0, ra} - {1'b0, rb} - 17'(rbin);
      en       = 1'b1;
      accept(ra, rb, rbin);
      cyc = 0;
      while (!out_valid && cyc < 300) begin
        en = ($urandom_range(0, 3) != 0);
        tick();
        cyc++;
      end
      en = 1'b1;
      n_checks++;
      if (!out_valid) begin
        n_errors++;
        $display("FAIL rand_timeout[%0d]: no o_valid after %0d cycles", n, cyc);
      end
      for (int d = $urandom_range(0, 3); d > 0; d--) begin
        en = 1'($urandom_range(0, 1));
        tick();
      end
      en = 1'b1;
      n_checks++;
      if ({bout, diff} !== exp_full) begin
        n_errors++;
        $display("FAIL rand_result[%0d]: a=%h b=%h bin=%b got bout=%b diff=%h, want %b %h",
                 n, ra, rb, rbin, bout, diff, exp_full[16], exp_full[15:0]);
      end
      release_result();
    end
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    bin      = 1'b0;
    ds_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_enable_stall();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
